// File: rtl/cpu_pkg.sv
// Shared constants and types for the CPU writeback slice.
// Used by cpu_load_align and cpu_writeback.
package cpu_pkg;

  // Default widths of the register file write port
  localparam int IDX_WIDTH_DEFAULT  = 5;
  localparam int DATA_WIDTH_DEFAULT = 32;
  localparam int REG_COUNT_DEFAULT  = 32;

  // Encoding of the load width field; 2'b11 is treated as a full word
  localparam logic [1:0] MEM_WIDTH_BYTE = 2'b00;
  localparam logic [1:0] MEM_WIDTH_HALF = 2'b01;
  localparam logic [1:0] MEM_WIDTH_WORD = 2'b10;

  // Hard-wired zero register: writes are dropped, never reported busy
  localparam int REG_X0 = 0;

  // Which producer owns the write port in a given cycle
  typedef enum logic [1:0] {
    WB_SRC_NONE = 2'b00,
    WB_SRC_ALU  = 2'b01,
    WB_SRC_MEM  = 2'b10
  } wb_src_e;

endpackage

// File: rtl/cpu_load_align.sv
// Load data formatter: picks the addressed byte/half lane out of an
// aligned 32-bit memory word and sign- or zero-extends it.
// Purely combinational. A half access uses only address bit 1; bit 0
// is ignored because misalignment is trapped elsewhere.
module cpu_load_align
  import cpu_pkg::*;
(
  input  logic [31:0] i_data,
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_width,
  input  logic        i_signed,
  output logic [31:0] o_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Lane select for byte and half accesses
  always_comb begin
    byte_lane = 8'h00;
    case (i_addr_lo)
      2'd0:    byte_lane = i_data[7:0];
      2'd1:    byte_lane = i_data[15:8];
      2'd2:    byte_lane = i_data[23:16];
      default: byte_lane = i_data[31:24];
    endcase
    half_lane = i_addr_lo[1] ? i_data[31:16] : i_data[15:0];
  end

  // Width-dependent extension to the full register width
  always_comb begin
    o_data = i_data;
    case (i_width)
      MEM_WIDTH_BYTE: o_data = {{24{i_signed & byte_lane[7]}}, byte_lane};
      MEM_WIDTH_HALF: o_data = {{16{i_signed & half_lane[15]}}, half_lane};
      default:        o_data = i_data;
    endcase
  end

endmodule

// File: rtl/cpu_writeback.sv
// Register file write side: arbitrates ALU and load results onto the
// single write port, formats load data and keeps the pending-write
// scoreboard that decode uses for RAW stalls.
// Optional feature macro: CPU_WRITEBACK_BYPASS_EN adds a same-cycle
// bypass of the winning result and lets it suppress busy queries.
module cpu_writeback
  import cpu_pkg::*;
#(
  parameter int REG_COUNT    = REG_COUNT_DEFAULT,
  parameter int IDX_WIDTH    = IDX_WIDTH_DEFAULT,
  parameter int DATA_WIDTH   = DATA_WIDTH_DEFAULT,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_issue_valid,
  input  logic [IDX_WIDTH-1:0]  i_issue_rd,
  input  logic [IDX_WIDTH-1:0]  i_query_rs1,
  input  logic [IDX_WIDTH-1:0]  i_query_rs2,
  output logic                  o_rs1_busy,
  output logic                  o_rs2_busy,
  input  logic                  i_alu_valid,
  output logic                  o_alu_ready,
  input  logic [IDX_WIDTH-1:0]  i_alu_rd,
  input  logic [DATA_WIDTH-1:0] i_alu_result,
  input  logic                  i_mem_valid,
  output logic                  o_mem_ready,
  input  logic [IDX_WIDTH-1:0]  i_mem_rd,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  input  logic [1:0]            i_mem_addr_lo,
  input  logic [1:0]            i_mem_width,
  input  logic                  i_mem_signed,
  output logic [IDX_WIDTH-1:0]  o_rd_idx,
  output logic [DATA_WIDTH-1:0] o_rd,
  output logic                  o_wr_request
`ifdef CPU_WRITEBACK_BYPASS_EN
  ,
  output logic                  o_bypass_valid,
  output logic [IDX_WIDTH-1:0]  o_bypass_idx,
  output logic [DATA_WIDTH-1:0] o_bypass_data
`endif
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic [IDX_WIDTH-1:0] X0_IDX = IDX_WIDTH'(REG_X0);

  logic [CNT_W-1:0]      starve_cnt;
  logic [REG_COUNT-1:0]  busy_q;
  logic [REG_COUNT-1:0]  busy_d;

  logic                  alu_grant;
  logic                  mem_grant;
  wb_src_e               win_src;
  logic                  win_xfer;
  logic                  win_write;
  logic [IDX_WIDTH-1:0]  win_rd;
  logic [DATA_WIDTH-1:0] win_data;
  logic [DATA_WIDTH-1:0] load_data;

  logic                  rs1_pending;
  logic                  rs2_pending;

  cpu_load_align u_load_align (
    .i_data    (i_mem_data),
    .i_addr_lo (i_mem_addr_lo),
    .i_width   (i_mem_width),
    .i_signed  (i_mem_signed),
    .o_data    (load_data)
  );

  // Loads win by default; a starved ALU takes the next contested cycle
  always_comb begin
    alu_grant = 1'b0;
    mem_grant = 1'b0;
    if (!i_reset) begin
      alu_grant = i_alu_valid && (!i_mem_valid || (starve_cnt >= STARVE_MAX));
      mem_grant = i_mem_valid && !alu_grant;
    end
  end

  assign o_alu_ready = alu_grant;
  assign o_mem_ready = mem_grant;

  // Select the winning producer's destination and formatted data
  always_comb begin
    win_src  = WB_SRC_NONE;
    win_rd   = '0;
    win_data = '0;
    if (alu_grant) begin
      win_src  = WB_SRC_ALU;
      win_rd   = i_alu_rd;
      win_data = i_alu_result;
    end else if (mem_grant) begin
      win_src  = WB_SRC_MEM;
      win_rd   = i_mem_rd;
      win_data = load_data;
    end
  end

  assign win_xfer  = (win_src != WB_SRC_NONE);
  assign win_write = win_xfer && (win_rd != X0_IDX);

  // Count consecutive ALU losses; any grant or idle ALU restarts the count
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      starve_cnt <= '0;
    end else if (!i_alu_valid || alu_grant) begin
      starve_cnt <= '0;
    end else if (starve_cnt < STARVE_MAX) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Next scoreboard: clear on accepted writeback, then set on issue so a
  // same-edge issue of the same register keeps it pending
  always_comb begin
    busy_d = busy_q;
    if (win_write) begin
      busy_d[win_rd] = 1'b0;
    end
    if (i_issue_valid && (i_issue_rd != X0_IDX)) begin
      busy_d[i_issue_rd] = 1'b1;
    end
  end

  // Scoreboard register
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Register file write port: one-cycle strobe, index/data hold otherwise
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_rd_idx     <= '0;
      o_rd         <= '0;
      o_wr_request <= 1'b0;
    end else if (win_write) begin
      o_rd_idx     <= win_rd;
      o_rd         <= win_data;
      o_wr_request <= 1'b1;
    end else begin
      o_wr_request <= 1'b0;
    end
  end

  assign rs1_pending = busy_q[i_query_rs1] && (i_query_rs1 != X0_IDX);
  assign rs2_pending = busy_q[i_query_rs2] && (i_query_rs2 != X0_IDX);

`ifdef CPU_WRITEBACK_BYPASS_EN
  assign o_bypass_valid = win_write;
  assign o_bypass_idx   = win_rd;
  assign o_bypass_data  = win_data;

  // A result being accepted this cycle can be forwarded, so it no longer stalls
  always_comb begin
    o_rs1_busy = rs1_pending && !(o_bypass_valid && (i_query_rs1 == o_bypass_idx));
    o_rs2_busy = rs2_pending && !(o_bypass_valid && (i_query_rs2 == o_bypass_idx));
  end
`else
  // Without bypass, only the registered scoreboard decides
  always_comb begin
    o_rs1_busy = rs1_pending;
    o_rs2_busy = rs2_pending;
  end
`endif

endmodule
